// File: rtl/gauss3x3_filter.sv
// gauss3x3_filter
//   3x3 Gaussian smoothing (1-2-1 / 2-4-2 / 1-2-1, divide by 16, round half up)
//   fed by a two-line row buffer. Emits one pixel per interior frame position,
//   in raster order. Border positions produce no output.
//   Optional macro FRAME_MARKERS_EN adds sof_out / eol_out frame markers.
//
//   Stream semantics: there is no backpressure. valid_in qualifies row0_in in
//   the beat cycle; row1_in/row2_in for that beat arrive one cycle later.
//   valid_out is a one-cycle pulse qualifying pix_out (and markers).
module gauss3x3_filter #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] row0_in,
  input  logic [DATA_WIDTH-1:0] row1_in,
  input  logic [DATA_WIDTH-1:0] row2_in,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] pix_out
`ifdef FRAME_MARKERS_EN
  ,
  output logic                  sof_out,
  output logic                  eol_out
`endif
);

  localparam int CW = (IMG_WIDTH  > 2) ? $clog2(IMG_WIDTH)  : 2;
  localparam int RW = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 2;
  localparam int SW = DATA_WIDTH + 4;

  // Stage 0: input position counters and delayed current-row tap
  logic [CW-1:0]         r_in_col;
  logic [RW-1:0]         r_in_row;
  logic [DATA_WIDTH-1:0] r_r0_d;
  logic                  r_v1;
  logic [CW-1:0]         r_col1;
  logic [RW-1:0]         r_row1;

  // Stage 1: 3x3 window; first index = row (0 newest row), second = column (2 newest)
  logic [DATA_WIDTH-1:0] r_win [0:2][0:2];
  logic                  r_v2;
  logic [CW-1:0]         r_col2;
  logic [RW-1:0]         r_row2;

  // Stage 2: output registers
  logic                  r_valid_out;
  logic [DATA_WIDTH-1:0] r_pix_out;
  logic                  r_sof;
  logic                  r_eol;

  logic [SW-1:0]         w_sum;
  logic [SW-1:0]         w_rounded;
  logic [DATA_WIDTH-1:0] w_pix;
  logic                  w_emit;

  // Stage 0: register the current-row tap and tag it with its raster position
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_in_col <= '0;
      r_in_row <= '0;
      r_r0_d   <= '0;
      r_v1     <= 1'b0;
      r_col1   <= '0;
      r_row1   <= '0;
    end else begin
      r_v1 <= valid_in;
      if (valid_in) begin
        r_r0_d <= row0_in;
        r_col1 <= r_in_col;
        r_row1 <= r_in_row;
        if (r_in_col == CW'(IMG_WIDTH - 1)) begin
          r_in_col <= '0;
          r_in_row <= (r_in_row == RW'(IMG_HEIGHT - 1)) ? '0 : r_in_row + RW'(1);
        end else begin
          r_in_col <= r_in_col + CW'(1);
        end
      end
    end
  end

  // Stage 1: shift the column triple into the window; stale columns are gated later
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          r_win[i][j] <= '0;
        end
      end
      r_v2   <= 1'b0;
      r_col2 <= '0;
      r_row2 <= '0;
    end else begin
      r_v2 <= r_v1;
      if (r_v1) begin
        for (int i = 0; i < 3; i++) begin
          r_win[i][0] <= r_win[i][1];
          r_win[i][1] <= r_win[i][2];
        end
        r_win[0][2] <= r_r0_d;
        r_win[1][2] <= row1_in;
        r_win[2][2] <= row2_in;
        r_col2      <= r_col1;
        r_row2      <= r_row1;
      end
    end
  end

  // Weighted window sum with rounding; the result never exceeds DATA_WIDTH bits
  always_comb begin
    w_sum = SW'(r_win[0][0]) + (SW'(r_win[0][1]) << 1) + SW'(r_win[0][2])
          + (SW'(r_win[1][0]) << 1) + (SW'(r_win[1][1]) << 2) + (SW'(r_win[1][2]) << 1)
          + SW'(r_win[2][0]) + (SW'(r_win[2][1]) << 1) + SW'(r_win[2][2]);
    w_rounded = w_sum + SW'(8);
  end

  assign w_pix  = DATA_WIDTH'(w_rounded >> 4);
  assign w_emit = r_v2 && (r_col2 >= CW'(2)) && (r_row2 >= RW'(2));

  // Stage 2: emit only when the window covers a full interior neighbourhood
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid_out <= 1'b0;
      r_pix_out   <= '0;
      r_sof       <= 1'b0;
      r_eol       <= 1'b0;
    end else begin
      r_valid_out <= w_emit;
      r_sof       <= w_emit && (r_row2 == RW'(2)) && (r_col2 == CW'(2));
      r_eol       <= w_emit && (r_col2 == CW'(IMG_WIDTH - 1));
      if (w_emit) begin
        r_pix_out <= w_pix;
      end
    end
  end

  assign valid_out = r_valid_out;
  assign pix_out   = r_pix_out;

`ifdef FRAME_MARKERS_EN
  assign sof_out = r_sof;
  assign eol_out = r_eol;
`else
  logic w_markers_unused;
  assign w_markers_unused = r_sof ^ r_eol;
`endif

endmodule

// File: tb/tb_gauss3x3_filter.sv
// tb_gauss3x3_filter
//   Randomized stream bench for gauss3x3_filter. Images live in a 2D array;
//   the expected output of each interior beat is a plain 3x3 convolution of
//   that array, queued with the cycle on which it must appear.
//   Build with FRAME_MARKERS_EN defined to also check sof_out / eol_out.
module tb_gauss3x3_filter;

  localparam int DW   = 8;
  localparam int IW   = 32;
  localparam int IH   = 32;
  localparam int NOUT = (IW - 2) * (IH - 2);

  // clock / reset block
  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          valid_in = 1'b0;
  logic [DW-1:0] row0_in = '0;
  logic [DW-1:0] row1_in = '0;
  logic [DW-1:0] row2_in = '0;
  logic          valid_out;
  logic [DW-1:0] pix_out;
`ifdef FRAME_MARKERS_EN
  logic          sof_out;
  logic          eol_out;
`endif

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  gauss3x3_filter #(
    .DATA_WIDTH (DW),
    .IMG_WIDTH  (IW),
    .IMG_HEIGHT (IH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .valid_in  (valid_in),
    .row0_in   (row0_in),
    .row1_in   (row1_in),
    .row2_in   (row2_in),
    .valid_out (valid_out),
    .pix_out   (pix_out)
`ifdef FRAME_MARKERS_EN
    ,
    .sof_out   (sof_out),
    .eol_out   (eol_out)
`endif
  );

  // scoreboard state
  logic [DW-1:0] exp_q[$];
  int unsigned   exp_cyc_q[$];
  int            exp_ctr_q[$];
  logic [1:0]    exp_mk_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            n_outs   = 0;
  int            n_sof    = 0;
  int            n_eol    = 0;
  bit            impulse_active = 1'b0;

  // reference image and pending row-buffer taps
  logic [DW-1:0] img [IH][IW];
  bit            pend_valid = 1'b0;
  logic [DW-1:0] pend1;
  logic [DW-1:0] pend2;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Gaussian value of the neighbourhood centred on (r,c) of the current image
  function automatic int gauss_at(input int r, input int c);
    int s;
    int k;
    s = 0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        k = ((dr == 0) ? 2 : 1) * ((dc == 0) ? 2 : 1);
        s += k * int'(img[r + dr][c + dc]);
      end
    end
    return (s + 8) / 16;
  endfunction

  // mode 0 const 100, 1 impulse, 2 all 255, 3 column ramp, 4 random
  task automatic fill_image(input int mode);
    for (int r = 0; r < IH; r++) begin
      for (int c = 0; c < IW; c++) begin
        case (mode)
          0:       img[r][c] = DW'(100);
          1:       img[r][c] = (r == 5 && c == 5) ? DW'(160) : DW'(0);
          2:       img[r][c] = DW'(255);
          3:       img[r][c] = DW'(c);
          default: img[r][c] = DW'($urandom);
        endcase
      end
    end
  endtask

  // driver: one cycle; also presents the previous beat's registered taps
  task automatic drive_beat(input bit v, input int r, input int c);
    @(negedge clk);
    if (pend_valid) begin
      row1_in = pend1;
      row2_in = pend2;
    end else begin
      row1_in = DW'($urandom);
      row2_in = DW'($urandom);
    end
    valid_in = v;
    if (v) begin
      row0_in = img[r][c];
      pend1   = (r >= 1) ? img[r-1][c] : DW'($urandom);
      pend2   = (r >= 2) ? img[r-2][c] : DW'($urandom);
      if (r >= 2 && c >= 2) begin
        exp_q.push_back(DW'(gauss_at(r - 1, c - 1)));
        exp_cyc_q.push_back(cyc + 3);
        exp_ctr_q.push_back((r - 1) * IW + (c - 1));
        exp_mk_q.push_back({(r == 2 && c == 2), (c == IW - 1)});
      end
    end else begin
      row0_in = DW'($urandom);
    end
    pend_valid = v;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_beat(1'b0, 0, 0);
  endtask

  task automatic drive_frame(input int mode, input int gap_pct, input int stop_row);
    fill_image(mode);
    for (int r = 0; r < IH; r++) begin
      if (r == stop_row) return;
      for (int c = 0; c < IW; c++) begin
        for (int g = 0; g < 4 && $urandom_range(99) < gap_pct; g++) drive_beat(1'b0, 0, 0);
        drive_beat(1'b1, r, c);
      end
    end
  endtask

  task automatic drain_and_count(input string name, input int exp_n);
    idle(8);
    check({name, "_count"}, n_outs, exp_n);
    check({name, "_queue_empty"}, exp_q.size(), 0);
    n_outs = 0;
  endtask

  // compare process: every valid output must match the head of the queue
  always @(negedge clk) begin
    if (reset_n && valid_out) begin
      n_outs++;
      if (exp_q.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        logic [DW-1:0] e_pix;
        int unsigned   e_cyc;
        int            e_ctr;
        logic [1:0]    e_mk;
        e_pix = exp_q.pop_front();
        e_cyc = exp_cyc_q.pop_front();
        e_ctr = exp_ctr_q.pop_front();
        e_mk  = exp_mk_q.pop_front();
        check("pix_out", pix_out, e_pix);
        check("latency_cycle", cyc, e_cyc);
        if (impulse_active) begin
          if (e_ctr == 5 * IW + 5) check("impulse_5_5", pix_out, 40);
          if (e_ctr == 4 * IW + 5) check("impulse_4_5", pix_out, 20);
          if (e_ctr == 4 * IW + 4) check("impulse_4_4", pix_out, 10);
          if (e_ctr == 3 * IW + 3) check("impulse_3_3", pix_out, 0);
        end
`ifdef FRAME_MARKERS_EN
        check("sof_out", sof_out, e_mk[1]);
        check("eol_out", eol_out, e_mk[0]);
        if (sof_out) n_sof++;
        if (eol_out) n_eol++;
`endif
      end
    end
`ifdef FRAME_MARKERS_EN
    else if (reset_n) begin
      check("sof_idle", sof_out, 0);
      check("eol_idle", eol_out, 0);
    end
`endif
  end

  initial begin
    // reset state
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_valid_out", valid_out, 0);
    check("reset_pix_out", pix_out, 0);
    reset_n = 1'b1;

    // model pins
    fill_image(1);
    check("model_impulse_5_5", gauss_at(5, 5), 40);
    check("model_impulse_4_5", gauss_at(4, 5), 20);
    check("model_impulse_4_4", gauss_at(4, 4), 10);
    check("model_impulse_3_3", gauss_at(3, 3), 0);
    fill_image(2);
    check("model_all_255", gauss_at(10, 10), 255);
    fill_image(3);
    check("model_ramp", gauss_at(7, 9), 9);

    // constant frame, continuous
    drive_frame(0, 0, IH);
    drain_and_count("const100", NOUT);

    // impulse frame
    impulse_active = 1'b1;
    drive_frame(1, 0, IH);
    drain_and_count("impulse", NOUT);
    impulse_active = 1'b0;

    // saturated frame
    drive_frame(2, 0, IH);
    drain_and_count("all255", NOUT);

    // ramp, continuous then with ~50% gaps
    drive_frame(3, 0, IH);
    drain_and_count("ramp", NOUT);
    drive_frame(3, 50, IH);
    drain_and_count("ramp_gaps", NOUT);

    // random content with gaps
    drive_frame(4, 30, IH);
    drain_and_count("random_gaps", NOUT);

    // reset in the middle of row 10
    drive_frame(4, 0, 10);
    @(negedge clk);
    reset_n  = 1'b0;
    valid_in = 1'b0;
    #1;
    check("midreset_valid_out", valid_out, 0);
    check("midreset_pix_out", pix_out, 0);
    exp_q.delete();
    exp_cyc_q.delete();
    exp_ctr_q.delete();
    exp_mk_q.delete();
    pend_valid = 1'b0;
    n_outs     = 0;
    repeat (3) @(negedge clk);
    check("midreset_hold_valid", valid_out, 0);
    reset_n = 1'b1;
    drive_frame(4, 0, IH);
    drain_and_count("after_reset", NOUT);

    // two back-to-back frames, no bubble between them
    n_sof = 0;
    n_eol = 0;
    drive_frame(4, 0, IH);
    drive_frame(4, 10, IH);
    drain_and_count("back_to_back", 2 * NOUT);
`ifdef FRAME_MARKERS_EN
    check("sof_pulses", n_sof, 2);
    check("eol_pulses", n_eol, 2 * (IH - 2));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
